// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - radix-4 Booth sequential multiplier, start/busy/done handshake
// Optional overflow flag output enabled by defining MULT_OVF_FLAG_EN.
module booth_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 start,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
`ifdef MULT_OVF_FLAG_EN
  ,
  output logic                 ovf
`endif
);

  localparam int LAT = WIDTH / 2 + 1;
  localparam int AW  = WIDTH + 4;
  localparam int MW  = WIDTH + 2;
  localparam int CW  = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [AW-1:0] mcand, acc, pp, sum, acc_nxt;
  logic [MW-1:0] mr, mr_nxt;
  logic          prev;
  logic          accept, step, last;
  logic [2*WIDTH-1:0] prod;
`ifdef MULT_OVF_FLAG_EN
  logic          sgn;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    if (en) begin
      case (state)
        IDLE: if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
        RUN: begin
          step = 1'b1;
          if (cnt == CW'(1)) begin
            last      = 1'b1;
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (start) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Booth digit from {b[2i+1], b[2i], b[2i-1]}; mr[1:0] are the next two multiplier bits
  always_comb begin
    case ({mr[1:0], prev})
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = ~(mcand << 1) + AW'(1);
      3'b101, 3'b110: pp = ~mcand + AW'(1);
      default:        pp = '0;
    endcase
  end

  assign sum     = acc + pp;
  assign acc_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign mr_nxt  = {sum[1:0], mr[MW-1:2]};
  // After the final shift the multiplier register holds the low MW product bits
  assign prod    = {acc_nxt[WIDTH-3:0], mr_nxt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      acc    <= '0;
      mr     <= '0;
      prev   <= 1'b0;
      cnt    <= '0;
      result <= '0;
`ifdef MULT_OVF_FLAG_EN
      sgn    <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      mcand <= signed_i ? {{4{a[WIDTH-1]}}, a} : {4'b0, a};
      mr    <= signed_i ? {{2{b[WIDTH-1]}}, b} : {2'b0, b};
      acc   <= '0;
      prev  <= 1'b0;
      cnt   <= CW'(LAT);
`ifdef MULT_OVF_FLAG_EN
      sgn   <= signed_i;
`endif
    end else if (step) begin
      acc  <= acc_nxt;
      mr   <= mr_nxt;
      prev <= mr[1];
      cnt  <= cnt - CW'(1);
      if (last) begin
        result <= prod;
`ifdef MULT_OVF_FLAG_EN
        if (sgn) ovf <= !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        else     ovf <= |prod[2*WIDTH-1:WIDTH];
`endif
      end
    end
  end

endmodule
